// File: rtl/mw_control_pipe.sv
// Memory/writeback control stage between X and W.
// Decodes writeback controls, sequences dmem and extracts load data.
module mw_control_pipe #(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            x_valid,
  output logic            x_ready,
  input  logic [6:0]      x_opcode,
  input  logic [2:0]      x_funct3,
  input  logic [4:0]      x_rd,
  input  logic [XLEN-1:0] x_addr,
  input  logic [XLEN-1:0] x_store_data,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [NB-1:0]   dmem_w_mask,
  output logic            dmem_re,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            w_valid,
  output logic [1:0]      w_wb_sel,
  output logic            w_rwe,
  output logic [4:0]      w_rd,
  output logic [XLEN-1:0] w_load_data,
  output logic            mem_fault
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam bit IS64 = (XLEN == 64);
  localparam logic [NB:0] ONE_W = {{NB{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic            dec_load;
  logic            dec_store;
  logic            dec_alu;
  logic            dec_jmp;
  logic [1:0]      dec_wb_sel;
  logic            dec_base_rwe;
  logic            dec_legal;
  logic            dec_misal;
  logic            dec_fault;
  logic            dec_go;
  logic            dec_rwe;
  logic [OFFW-1:0] dec_off;
  logic [3:0]      dec_nbytes;
  logic [3:0]      dec_am;
  logic [NB:0]     dec_bm_w;
  logic [NB-1:0]   dec_bm;
  logic [XLEN-1:0] dec_bexp;
  logic [NB-1:0]   dec_mask;
  logic [XLEN-1:0] dec_wdata;
  logic [XLEN-1:0] dec_addr;
  logic            accept;

  logic [1:0]      size_q;
  logic [OFFW-1:0] off_q;
  logic            zext_q;
  logic            load_q;
  logic            re_q;
  logic [1:0]      wb_sel_p_q;
  logic            rwe_p_q;
  logic [4:0]      rd_p_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [NB-1:0]   mask_q;

  logic [1:0]      w_wb_sel_q;
  logic            w_rwe_q;
  logic [4:0]      w_rd_q;
  logic [XLEN-1:0] w_ld_q;
  logic            fault_q;

  logic [XLEN-1:0] ld_sh;
  logic [NB:0]     ld_bm_w;
  logic [XLEN-1:0] ld_bexp;
  logic            ld_sgn;
  logic [XLEN-1:0] ld_val;

  // Opcode class decode and writeback controls
  always_comb begin
    dec_load     = (x_opcode == OP_LOAD);
    dec_store    = (x_opcode == OP_STORE);
    dec_alu      = (x_opcode inside {OP_OP, OP_IMM, OP_LUI, OP_AUIPC});
    dec_jmp      = (x_opcode inside {OP_JAL, OP_JALR});
    dec_wb_sel   = 2'd0;
    dec_base_rwe = 1'b0;
    unique case (1'b1)
      dec_load: begin
        dec_wb_sel   = 2'd0;
        dec_base_rwe = 1'b1;
      end
      dec_alu: begin
        dec_wb_sel   = 2'd1;
        dec_base_rwe = 1'b1;
      end
      dec_jmp: begin
        dec_wb_sel   = 2'd2;
        dec_base_rwe = 1'b1;
      end
      default: ;
    endcase
  end

  // Legality, alignment, lane mask and shifted store data
  always_comb begin
    dec_legal = 1'b0;
    if (dec_load)
      dec_legal = (x_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
               || (IS64 && (x_funct3 inside {3'd3, 3'd6}));
    else if (dec_store)
      dec_legal = !x_funct3[2] && ((x_funct3[1:0] != 2'd3) || IS64);
    dec_off    = x_addr[OFFW-1:0];
    dec_nbytes = 4'd1 << x_funct3[1:0];
    dec_am     = dec_nbytes - 4'd1;
    dec_misal  = |(dec_off & dec_am[OFFW-1:0]);
    dec_fault  = (dec_load || dec_store) && (!dec_legal || dec_misal);
    dec_go     = (dec_load || dec_store) && !dec_fault;
    dec_rwe    = dec_base_rwe && (x_rd != 5'd0) && !dec_fault;
    dec_bm_w   = (ONE_W << dec_nbytes) - ONE_W;
    dec_bm     = dec_bm_w[NB-1:0];
    for (int i = 0; i < NB; i++)
      dec_bexp[8*i +: 8] = {8{dec_bm[i]}};
    dec_mask  = dec_store ? (dec_bm << dec_off) : '0;
    dec_wdata = dec_store
              ? ((x_store_data & dec_bexp) << {dec_off, 3'b000})
              : '0;
    dec_addr  = {x_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  end

  // Shift response to lane 0, then sign/zero-extend from access size
  always_comb begin
    ld_sh   = dmem_rdata >> {off_q, 3'b000};
    ld_bm_w = (ONE_W << (4'd1 << size_q)) - ONE_W;
    for (int i = 0; i < NB; i++)
      ld_bexp[8*i +: 8] = {8{ld_bm_w[i]}};
    unique case (size_q)
      2'd0:    ld_sgn = ld_sh[7];
      2'd1:    ld_sgn = ld_sh[15];
      2'd2:    ld_sgn = ld_sh[31];
      default: ld_sgn = ld_sh[XLEN-1];
    endcase
    ld_val = (ld_sh & ld_bexp)
           | (~ld_bexp & {XLEN{ld_sgn & ~zext_q}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (x_valid) state_d = dec_go ? REQ : DONE;
        else         state_d = IDLE;
      end
      REQ:  if (dmem_req_ready) state_d = load_q ? WAIT : DONE;
      WAIT: if (dmem_resp_valid) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_ready        = 1'b0;
    dmem_req_valid = 1'b0;
    w_valid        = 1'b0;
    unique case (state_q)
      IDLE: x_ready = 1'b1;
      REQ:  dmem_req_valid = 1'b1;
      DONE: begin
        x_ready = 1'b1;
        w_valid = 1'b1;
      end
      default: ;
    endcase
    dmem_re     = dmem_req_valid & re_q;
    dmem_w_mask = dmem_req_valid ? mask_q : '0;
    mem_fault   = w_valid & fault_q;
  end

  assign accept     = x_valid & x_ready;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  // Request fields stay frozen from acceptance until the next accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q     <= '0;
      off_q      <= '0;
      zext_q     <= 1'b0;
      load_q     <= 1'b0;
      re_q       <= 1'b0;
      wb_sel_p_q <= '0;
      rwe_p_q    <= 1'b0;
      rd_p_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
    end else if (accept) begin
      size_q     <= x_funct3[1:0];
      off_q      <= dec_off;
      zext_q     <= x_funct3[2];
      load_q     <= dec_load;
      re_q       <= dec_load & dec_go;
      wb_sel_p_q <= dec_wb_sel;
      rwe_p_q    <= dec_rwe;
      rd_p_q     <= x_rd;
      addr_q     <= dec_addr;
      wdata_q    <= dec_wdata;
      mask_q     <= dec_mask;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_wb_sel_q <= '0;
      w_rwe_q    <= 1'b0;
      w_rd_q     <= '0;
      w_ld_q     <= '0;
      fault_q    <= 1'b0;
    end else if (accept && !dec_go) begin
      w_wb_sel_q <= dec_wb_sel;
      w_rwe_q    <= dec_rwe;
      w_rd_q     <= x_rd;
      fault_q    <= dec_fault;
    end else if (state_q == REQ && dmem_req_ready && !load_q) begin
      w_wb_sel_q <= wb_sel_p_q;
      w_rwe_q    <= rwe_p_q;
      w_rd_q     <= rd_p_q;
      fault_q    <= 1'b0;
    end else if (state_q == WAIT && dmem_resp_valid) begin
      w_wb_sel_q <= wb_sel_p_q;
      w_rwe_q    <= rwe_p_q;
      w_rd_q     <= rd_p_q;
      w_ld_q     <= ld_val;
      fault_q    <= 1'b0;
    end
  end

  assign w_wb_sel    = w_wb_sel_q;
  assign w_rwe       = w_rwe_q;
  assign w_rd        = w_rd_q;
  assign w_load_data = w_ld_q;

endmodule

// File: tb/tb_mw_control_pipe.sv
// Directed bench for mw_control_pipe.
// Runs an XLEN=32 and an XLEN=64 instance side by side.
module tb_mw_control_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  int          ntests = 0;
  int          nfail = 0;

  logic        x_valid, x_ready;
  logic [6:0]  x_opcode;
  logic [2:0]  x_funct3;
  logic [4:0]  x_rd;
  logic [31:0] x_addr, x_store_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_re;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_w_mask;
  logic        dmem_resp_valid;
  logic        w_valid, w_rwe, mem_fault;
  logic [1:0]  w_wb_sel;
  logic [4:0]  w_rd;
  logic [31:0] w_load_data;

  logic        b_x_valid, b_x_ready;
  logic [6:0]  b_x_opcode;
  logic [2:0]  b_x_funct3;
  logic [4:0]  b_x_rd;
  logic [63:0] b_x_addr, b_x_store_data;
  logic        b_req_valid, b_req_ready, b_re;
  logic [63:0] b_addr, b_wdata, b_rdata;
  logic [7:0]  b_w_mask;
  logic        b_resp_valid;
  logic        b_w_valid, b_w_rwe, b_mem_fault;
  logic [1:0]  b_w_wb_sel;
  logic [4:0]  b_w_rd;
  logic [63:0] b_w_load_data;

  localparam logic [6:0] LOAD = 7'h03;
  localparam logic [6:0] STORE = 7'h23;
  localparam logic [6:0] OPR = 7'h33;
  localparam logic [6:0] JAL = 7'h6F;
  localparam logic [6:0] BRANCH = 7'h63;

  always #5 clk = ~clk;

  mw_control_pipe #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .x_valid(x_valid), .x_ready(x_ready),
    .x_opcode(x_opcode), .x_funct3(x_funct3), .x_rd(x_rd),
    .x_addr(x_addr), .x_store_data(x_store_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_w_mask(dmem_w_mask), .dmem_re(dmem_re),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
    .w_valid(w_valid), .w_wb_sel(w_wb_sel), .w_rwe(w_rwe),
    .w_rd(w_rd), .w_load_data(w_load_data), .mem_fault(mem_fault)
  );

  mw_control_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n),
    .x_valid(b_x_valid), .x_ready(b_x_ready),
    .x_opcode(b_x_opcode), .x_funct3(b_x_funct3), .x_rd(b_x_rd),
    .x_addr(b_x_addr), .x_store_data(b_x_store_data),
    .dmem_req_valid(b_req_valid), .dmem_req_ready(b_req_ready),
    .dmem_addr(b_addr), .dmem_wdata(b_wdata),
    .dmem_w_mask(b_w_mask), .dmem_re(b_re),
    .dmem_resp_valid(b_resp_valid), .dmem_rdata(b_rdata),
    .w_valid(b_w_valid), .w_wb_sel(b_w_wb_sel), .w_rwe(b_w_rwe),
    .w_rd(b_w_rd), .w_load_data(b_w_load_data), .mem_fault(b_mem_fault)
  );

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    x_opcode = op; x_funct3 = f3; x_rd = rd;
    x_addr = a; x_store_data = d; x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
  endtask

  task automatic issue64(input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [63:0] a,
                         input logic [63:0] d);
    @(negedge clk);
    b_x_opcode = op; b_x_funct3 = f3; b_x_rd = rd;
    b_x_addr = a; b_x_store_data = d; b_x_valid = 1'b1;
    @(posedge clk); #1;
    b_x_valid = 1'b0;
  endtask

  task automatic test_reset;
    ntests++; if (x_ready !== 1'b1) begin nfail++; $display("FAIL rst_x_ready got %b exp 1", x_ready); end
    ntests++; if (dmem_req_valid !== 1'b0) begin nfail++; $display("FAIL rst_req_valid got %b exp 0", dmem_req_valid); end
    ntests++; if (w_valid !== 1'b0 || w_rwe !== 1'b0 || mem_fault !== 1'b0) begin nfail++; $display("FAIL rst_w got v%b rwe%b f%b exp 000", w_valid, w_rwe, mem_fault); end
    ntests++; if (dmem_w_mask !== 4'h0 || dmem_re !== 1'b0 || dmem_addr !== 32'h0) begin nfail++; $display("FAIL rst_dmem got m%h re%b a%h exp 0", dmem_w_mask, dmem_re, dmem_addr); end
    ntests++; if (w_load_data !== 32'h0 || w_wb_sel !== 2'd0) begin nfail++; $display("FAIL rst_wdata got %h/%0d exp 0", w_load_data, w_wb_sel); end
  endtask

  task automatic test_store_word;
    issue(STORE, 3'b010, 5'd0, 32'h1004, 32'hDEADBEEF);
    ntests++; if (dmem_req_valid !== 1'b1 || x_ready !== 1'b0) begin nfail++; $display("FAIL sw_req got v%b rdy%b exp 1 0", dmem_req_valid, x_ready); end
    ntests++; if (dmem_addr !== 32'h1004) begin nfail++; $display("FAIL sw_addr got %h exp 00001004", dmem_addr); end
    ntests++; if (dmem_w_mask !== 4'b1111 || dmem_re !== 1'b0) begin nfail++; $display("FAIL sw_mask got %b re%b exp 1111 0", dmem_w_mask, dmem_re); end
    ntests++; if (dmem_wdata !== 32'hDEADBEEF) begin nfail++; $display("FAIL sw_wdata got %h exp deadbeef", dmem_wdata); end
    ntests++; if (w_valid !== 1'b0) begin nfail++; $display("FAIL sw_early_w got %b exp 0", w_valid); end
    @(posedge clk); #1;
    ntests++; if (w_valid !== 1'b1 || w_rwe !== 1'b0 || mem_fault !== 1'b0) begin nfail++; $display("FAIL sw_done got v%b rwe%b f%b exp 100", w_valid, w_rwe, mem_fault); end
    @(posedge clk); #1;
    ntests++; if (w_valid !== 1'b0 || x_ready !== 1'b1) begin nfail++; $display("FAIL sw_pulse got v%b rdy%b exp 0 1", w_valid, x_ready); end
  endtask

  task automatic test_store_byte;
    issue(STORE, 3'b000, 5'd0, 32'h1003, 32'h000000A5);
    ntests++; if (dmem_w_mask !== 4'b1000) begin nfail++; $display("FAIL sb_mask got %b exp 1000", dmem_w_mask); end
    ntests++; if (dmem_wdata !== 32'hA5000000) begin nfail++; $display("FAIL sb_wdata got %h exp a5000000", dmem_wdata); end
    ntests++; if (dmem_addr !== 32'h1000) begin nfail++; $display("FAIL sb_addr got %h exp 00001000", dmem_addr); end
    @(posedge clk); #1;
    ntests++; if (w_valid !== 1'b1) begin nfail++; $display("FAIL sb_done got %b exp 1", w_valid); end
  endtask

  task automatic test_load_half(input logic [2:0] f3, input logic [31:0] exp);
    issue(LOAD, f3, 5'd5, 32'h1002, 32'h0);
    ntests++; if (dmem_req_valid !== 1'b1 || dmem_re !== 1'b1 || dmem_w_mask !== 4'h0) begin nfail++; $display("FAIL lh_req got v%b re%b m%b exp 1 1 0000", dmem_req_valid, dmem_re, dmem_w_mask); end
    @(posedge clk); #1;
    ntests++; if (dmem_req_valid !== 1'b0 || x_ready !== 1'b0 || w_valid !== 1'b0) begin nfail++; $display("FAIL lh_wait got v%b rdy%b w%b exp 000", dmem_req_valid, x_ready, w_valid); end
    @(negedge clk);
    dmem_resp_valid = 1'b1; dmem_rdata = 32'h80011234;
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    ntests++; if (w_valid !== 1'b1 || w_load_data !== exp) begin nfail++; $display("FAIL lh_data f3=%0d got v%b %h exp 1 %h", f3, w_valid, w_load_data, exp); end
    ntests++; if (w_wb_sel !== 2'd0 || w_rwe !== 1'b1 || w_rd !== 5'd5) begin nfail++; $display("FAIL lh_ctl got sel%0d rwe%b rd%0d exp 0 1 5", w_wb_sel, w_rwe, w_rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_fault;
    issue(LOAD, 3'b010, 5'd6, 32'h1001, 32'h0);
    ntests++; if (dmem_req_valid !== 1'b0) begin nfail++; $display("FAIL lw_mis_req got %b exp 0", dmem_req_valid); end
    ntests++; if (w_valid !== 1'b1 || mem_fault !== 1'b1 || w_rwe !== 1'b0) begin nfail++; $display("FAIL lw_mis got v%b f%b rwe%b exp 1 1 0", w_valid, mem_fault, w_rwe); end
    @(posedge clk); #1;
    ntests++; if (mem_fault !== 1'b0) begin nfail++; $display("FAIL fault_pulse got %b exp 0", mem_fault); end
    issue(LOAD, 3'b011, 5'd6, 32'h1000, 32'h0);
    ntests++; if (dmem_req_valid !== 1'b0 || mem_fault !== 1'b1 || w_rwe !== 1'b0) begin nfail++; $display("FAIL ld32 got req%b f%b rwe%b exp 0 1 0", dmem_req_valid, mem_fault, w_rwe); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall;
    dmem_req_ready = 1'b0;
    issue(STORE, 3'b010, 5'd0, 32'h2008, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      ntests++; if (dmem_req_valid !== 1'b1 || x_ready !== 1'b0 || w_valid !== 1'b0) begin nfail++; $display("FAIL stall_ctl c%0d got v%b rdy%b w%b exp 1 0 0", i, dmem_req_valid, x_ready, w_valid); end
      ntests++; if (dmem_addr !== 32'h2008 || dmem_wdata !== 32'h12345678 || dmem_w_mask !== 4'hF) begin nfail++; $display("FAIL stall_data c%0d got %h %h %b", i, dmem_addr, dmem_wdata, dmem_w_mask); end
      if (i < 2) begin @(posedge clk); #1; end
    end
    @(negedge clk); dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    ntests++; if (w_valid !== 1'b1 || dmem_req_valid !== 1'b0) begin nfail++; $display("FAIL stall_done got w%b req%b exp 1 0", w_valid, dmem_req_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_rd0;
    issue(LOAD, 3'b010, 5'd0, 32'h1008, 32'h0);
    ntests++; if (dmem_req_valid !== 1'b1 || dmem_re !== 1'b1) begin nfail++; $display("FAIL rd0_req got v%b re%b exp 1 1", dmem_req_valid, dmem_re); end
    @(posedge clk); #1;
    @(negedge clk); dmem_resp_valid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1; dmem_resp_valid = 1'b0;
    ntests++; if (w_valid !== 1'b1 || w_rwe !== 1'b0 || w_load_data !== 32'hCAFEF00D) begin nfail++; $display("FAIL rd0_w got v%b rwe%b %h exp 1 0 cafef00d", w_valid, w_rwe, w_load_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [6:0] ops [3] = '{OPR, JAL, BRANCH};
    logic [1:0] sel [3] = '{2'd1, 2'd2, 2'd0};
    logic       rwe [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x_opcode = ops[i]; x_funct3 = 3'b000; x_rd = 5'(i + 1); x_valid = 1'b1;
      @(posedge clk); #1;
      ntests++; if (w_valid !== 1'b1 || w_wb_sel !== sel[i] || w_rwe !== rwe[i] || w_rd !== 5'(i + 1)) begin nfail++; $display("FAIL b2b_%0d got v%b sel%0d rwe%b rd%0d exp 1 %0d %b %0d", i, w_valid, w_wb_sel, w_rwe, w_rd, sel[i], rwe[i], i + 1); end
    end
    @(negedge clk); x_valid = 1'b0;
    @(posedge clk); #1;
    ntests++; if (w_valid !== 1'b0 || x_ready !== 1'b1 || w_wb_sel !== 2'd0) begin nfail++; $display("FAIL b2b_idle got v%b rdy%b sel%0d exp 0 1 0", w_valid, x_ready, w_wb_sel); end
  endtask

  task automatic test_reset_inflight;
    dmem_req_ready = 1'b0;
    issue(STORE, 3'b010, 5'd0, 32'h1000, 32'h1);
    #2 reset_n = 1'b0; #1;
    ntests++; if (dmem_req_valid !== 1'b0 || x_ready !== 1'b1) begin nfail++; $display("FAIL rst_req got v%b rdy%b exp 0 1", dmem_req_valid, x_ready); end
    @(negedge clk); reset_n = 1'b1; dmem_req_ready = 1'b1;
    issue(LOAD, 3'b010, 5'd4, 32'h1000, 32'h0);
    @(posedge clk); #1;
    ntests++; if (dmem_req_valid !== 1'b0 || x_ready !== 1'b0) begin nfail++; $display("FAIL rstw_wait got v%b rdy%b exp 0 0", dmem_req_valid, x_ready); end
    #2 reset_n = 1'b0; #1;
    ntests++; if (x_ready !== 1'b1 || dmem_req_valid !== 1'b0 || w_valid !== 1'b0) begin nfail++; $display("FAIL rstw_idle got rdy%b v%b w%b exp 1 0 0", x_ready, dmem_req_valid, w_valid); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); dmem_resp_valid = 1'b1; dmem_rdata = 32'h55;
    @(posedge clk); #1; dmem_resp_valid = 1'b0;
    ntests++; if (w_valid !== 1'b0 || w_load_data !== 32'h0) begin nfail++; $display("FAIL late_resp got w%b %h exp 0 0", w_valid, w_load_data); end
    @(posedge clk); #1;
    ntests++; if (w_valid !== 1'b0) begin nfail++; $display("FAIL late_resp2 got %b exp 0", w_valid); end
  endtask

  task automatic test_xlen64;
    logic [2:0]  f3s  [3] = '{3'b010, 3'b110, 3'b011};
    logic [63:0] adrs [3] = '{64'h2004, 64'h2004, 64'h2008};
    logic [63:0] rds  [3] = '{64'h8000_0000_1111_1111, 64'h8000_0000_1111_1111, 64'h8123_4567_89AB_CDEF};
    logic [63:0] exps [3] = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 64'h8123_4567_89AB_CDEF};
    issue64(STORE, 3'b000, 5'd0, 64'h2007, 64'hA5);
    ntests++; if (b_w_mask !== 8'h80 || b_req_valid !== 1'b1) begin nfail++; $display("FAIL sb64_mask got %h v%b exp 80 1", b_w_mask, b_req_valid); end
    ntests++; if (b_wdata !== 64'hA500_0000_0000_0000 || b_addr !== 64'h2000) begin nfail++; $display("FAIL sb64_data got %h %h", b_wdata, b_addr); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      issue64(LOAD, f3s[i], 5'd7, adrs[i], 64'h0);
      ntests++; if (b_req_valid !== 1'b1 || b_re !== 1'b1) begin nfail++; $display("FAIL ld64_req_%0d got v%b re%b exp 1 1", i, b_req_valid, b_re); end
      @(posedge clk); #1;
      @(negedge clk); b_resp_valid = 1'b1; b_rdata = rds[i];
      @(posedge clk); #1; b_resp_valid = 1'b0;
      ntests++; if (b_w_valid !== 1'b1 || b_w_load_data !== exps[i] || b_w_rwe !== 1'b1) begin nfail++; $display("FAIL ld64_%0d got v%b %h rwe%b exp %h", i, b_w_valid, b_w_load_data, b_w_rwe, exps[i]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    x_valid = 1'b0; x_opcode = '0; x_funct3 = '0; x_rd = '0;
    x_addr = '0; x_store_data = '0;
    dmem_req_ready = 1'b1; dmem_resp_valid = 1'b0; dmem_rdata = '0;
    b_x_valid = 1'b0; b_x_opcode = '0; b_x_funct3 = '0; b_x_rd = '0;
    b_x_addr = '0; b_x_store_data = '0;
    b_req_ready = 1'b1; b_resp_valid = 1'b0; b_rdata = '0;
    repeat (2) @(posedge clk);
    #1 test_reset();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_half(3'b001, 32'hFFFF8001);
    test_load_half(3'b101, 32'h00008001);
    test_fault();
    test_stall();
    test_rd0();
    test_back_to_back();
    test_reset_inflight();
    test_xlen64();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
